uart_frame_rx: RTL
==================

# uart_frame_rx

Byte-stream deframer that sits directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobes and hunts for a `0x55 0xAA` header. It then captures a length byte, a payload and an 8-bit additive checksum. Payload bytes are released on a valid/ready stream only after the checksum verifies, so the consumer never sees a corrupt frame; malformed, stalled or overrun traffic is reported as an error pulse with a code.

## Interface
- `MAX_LEN`, 16: maximum payload bytes per frame (1..255); also the buffer depth.
- `HDR0`, 8'h55: first header byte.
- `HDR1`, 8'hAA: second header byte.
- `TIMEOUT_CYC`, 32'd3840: idle clk cycles between bytes that aborts a partial frame (about 2 byte times at 22.1184 MHz / 115200).
- `clk`  input  1  system clock; the block has one clock.
- `rst_n`  input  1  synchronous reset, active-high (1 = reset), sampled on rising `clk`.
- `rx_vld_i`  input  1  one-cycle strobe: `rx_data_i` holds a received byte.
- `rx_data_i`  input  8  received byte.
- `pl_vld_o`  output  1  payload byte valid.
- `pl_data_o`  output  8  payload byte.
- `pl_last_o`  output  1  marks the final payload byte of a frame; only meaningful while `pl_vld_o` = 1.
- `pl_rdy_i`  input  1  consumer accepts the byte; a transfer occurs when `pl_vld_o && pl_rdy_i`.
- `frm_ok_o`  output  1  one-cycle pulse: frame verified.
- `frm_err_o`  output  1  one-cycle pulse: error detected.
- `err_code_o`  output  2  error code, valid with `frm_err_o`: 0 = LEN, 1 = CSUM, 2 = TMO, 3 = OVR. Holds its last value otherwise.
- `busy_o`  output  1  1 in every state except HUNT0.

## Operation
- States: HUNT0, HUNT1, LEN, DATA, CSUM, OUT.
- HUNT0: a byte equal to `HDR0` moves to HUNT1; any other byte is ignored.
- HUNT1 (re-sync rules):
  - `HDR1` moves to LEN.
  - `HDR0` stays in HUNT1.
  - Any other byte returns to HUNT0. No error is raised.
- LEN (length checks):
  - A length of 0 or greater than `MAX_LEN` raises LEN error and returns to HUNT0.
  - Otherwise the length is stored, the checksum accumulator is set to the length byte, the write index is cleared, and the state moves to DATA.
- DATA: each byte is written to `buf[wr_idx]` and added to the accumulator (8-bit wraparound). After the byte with index len-1 the state moves to CSUM.
- CSUM (checksum = (len + Σ payload) mod 256):
  - A received byte equal to the checksum moves to OUT and pulses `frm_ok_o`.
  - Any other value raises CSUM error and returns to HUNT0.
- OUT (stream-out):
  - `pl_vld_o` = 1, `pl_data_o` = `buf[rd_idx]`, and `pl_last_o` = 1 when `rd_idx` = len-1.
  - `rd_idx` advances on each transfer.
  - A transfer with `pl_last_o` = 1 returns to HUNT0.
- Overrun: a byte arriving during OUT is dropped and raises OVR error. The stream-out is unaffected.
- Timeout:
  - The idle counter clears on every `rx_vld_i` and in HUNT0/OUT, and saturates.
  - If it reaches `TIMEOUT_CYC` in HUNT1, LEN, DATA or CSUM, the block raises TMO error and returns to HUNT0.
- Errors are at most one per cycle, and every error abort discards the buffered data.

## Timing
- Reset values: all outputs 0, state HUNT0, indices and idle counter 0.
- A reset in any state (including mid-DATA or mid-OUT) discards the frame. The next cycle shows `pl_vld_o` = 0 and `busy_o` = 0.
- State, counters and pulse outputs are registered. `pl_data_o` is read from the buffer at `rd_idx`.
- Latency: for a checksum byte strobed in cycle N, cycle N+1 shows OUT, `frm_ok_o` = 1, `pl_vld_o` = 1 and byte 0.
- Each error pulse appears one cycle after the offending strobe, or one cycle after the counter reaches `TIMEOUT_CYC`.
- Valid/ready rules:
  - `pl_vld_o` never drops without a transfer.
  - `pl_data_o` and `pl_last_o` are stable while `pl_vld_o && !pl_rdy_i`.
  - With `pl_rdy_i` held at 1, the stream sustains 1 byte per cycle.
- Back-to-back: a header byte strobed in the same cycle as the final transfer is dropped as OVR. Upstream must respect this; UART byte spacing makes it rare.

## Structure
- Package `uart_frame_pkg` holds:
  - the state encoding localparams;
  - the error-code constants (LEN/CSUM/TMO/OVR);
  - the default header constants.
- Sub-module `uart_frame_buf`: a `MAX_LEN`×8 register file with one synchronous write port and one combinational read port. The FSM, counters and checksum stay in `uart_frame_rx`.

## Test plan
- Good frame: `55 AA 03 11 22 33 69` → `frm_ok_o` pulse, then stream `11`, `22`, `33` with `pl_last_o` = 1 on `33`; no error.
- Bad checksum: `55 AA 03 11 22 33 68` → `frm_err_o` with code 1, `pl_vld_o` never asserted, `busy_o` = 0 afterwards.
- Length limits:
  - `55 AA 00` → code 0.
  - `55 AA 11` (17 > 16) → code 0.
  - `55 AA 10` followed by 16 bytes and a correct checksum → ok.
- Re-sync: `55 55 AA 01 7E 7F` → ok, single byte `7E` with `pl_last_o` = 1.
- Timeout and recovery: `55 AA 02 10`, then 3840 idle cycles → code 2. A good frame sent afterwards is accepted.
- Backpressure, overrun and reset:
  - `pl_rdy_i` held 0 for 5 cycles on the good frame: data holds at `11`.
  - A byte strobed during OUT → code 3; the output sequence is unchanged.
  - `rst_n` = 1 mid-DATA: all outputs are 0 the next cycle, and the subsequent good frame is accepted.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame deframer: state encoding, error codes, header defaults.
package uart_frame_pkg;

  localparam int unsigned ST_W  = 3;
  localparam int unsigned ERR_W = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_HUNT0 = 3'd0;
  localparam state_t ST_HUNT1 = 3'd1;
  localparam state_t ST_LEN   = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_CSUM  = 3'd4;
  localparam state_t ST_OUT   = 3'd5;

  localparam logic [ERR_W-1:0] ERR_LEN  = 2'd0;
  localparam logic [ERR_W-1:0] ERR_CSUM = 2'd1;
  localparam logic [ERR_W-1:0] ERR_TMO  = 2'd2;
  localparam logic [ERR_W-1:0] ERR_OVR  = 2'd3;

  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Deframer: hunts for the two-byte header, buffers length+payload, verifies the additive
// checksum, then releases the payload on a valid/ready stream; errors pulse with a code.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [7:0]  HDR0        = HDR0_DEF,
  parameter logic [7:0]  HDR1        = HDR1_DEF,
  parameter logic [31:0] TIMEOUT_CYC = 32'd3840
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_vld_i,
  input  logic [7:0] rx_data_i,
  output logic       pl_vld_o,
  output logic [7:0] pl_data_o,
  output logic       pl_last_o,
  input  logic       pl_rdy_i,
  output logic       frm_ok_o,
  output logic       frm_err_o,
  output logic [1:0] err_code_o,
  output logic       busy_o
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_len;
  logic [7:0]      r_csum;
  logic [AW-1:0]   r_wr_idx;
  logic [AW-1:0]   r_rd_idx;
  logic [AW-1:0]   w_rd_idx_nxt;
  logic [31:0]     r_idle;
  logic            r_pl_vld;
  logic            r_pl_last;
  logic            r_frm_ok;
  logic            r_frm_err;
  logic [ERR_W-1:0] r_err_code;
  logic            r_busy;

  logic            w_ok;
  logic            w_err;
  logic [ERR_W-1:0] w_err_code;
  logic            w_len_ld;
  logic            w_wr_en;
  logic            w_tmo;
  logic            w_len_bad;
  logic            w_data_last;
  logic            w_xfer;
  logic [7:0]      w_rd_data;

  assign w_tmo       = (r_idle == TIMEOUT_CYC);
  assign w_len_bad   = (rx_data_i == 8'd0) || (rx_data_i > 8'(MAX_LEN));
  assign w_data_last = (8'(r_wr_idx) == (r_len - 8'd1));
  assign w_xfer      = r_pl_vld & pl_rdy_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) r_state <= ST_HUNT0;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; a timeout wins over a byte arriving in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HUNT0: if (rx_vld_i && (rx_data_i == HDR0)) w_state_nxt = ST_HUNT1;
      ST_HUNT1: begin
        if (w_tmo) w_state_nxt = ST_HUNT0;
        else if (rx_vld_i) begin
          if (rx_data_i == HDR1)      w_state_nxt = ST_LEN;
          else if (rx_data_i != HDR0) w_state_nxt = ST_HUNT0;
        end
      end
      ST_LEN: begin
        if (w_tmo)         w_state_nxt = ST_HUNT0;
        else if (rx_vld_i) w_state_nxt = w_len_bad ? ST_HUNT0 : ST_DATA;
      end
      ST_DATA: begin
        if (w_tmo)                         w_state_nxt = ST_HUNT0;
        else if (rx_vld_i && w_data_last)  w_state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        if (w_tmo)         w_state_nxt = ST_HUNT0;
        else if (rx_vld_i) w_state_nxt = (rx_data_i == r_csum) ? ST_OUT : ST_HUNT0;
      end
      ST_OUT:  if (w_xfer && r_pl_last) w_state_nxt = ST_HUNT0;
      default: w_state_nxt = ST_HUNT0;
    endcase
  end

  // Per-state actions: pulses, error code, buffer write and read-index update
  always_comb begin
    w_ok         = 1'b0;
    w_err        = 1'b0;
    w_err_code   = ERR_LEN;
    w_len_ld     = 1'b0;
    w_wr_en      = 1'b0;
    w_rd_idx_nxt = r_rd_idx;
    case (r_state)
      ST_HUNT1: if (w_tmo) begin w_err = 1'b1; w_err_code = ERR_TMO; end
      ST_LEN: begin
        if (w_tmo) begin
          w_err = 1'b1; w_err_code = ERR_TMO;
        end else if (rx_vld_i) begin
          if (w_len_bad) begin w_err = 1'b1; w_err_code = ERR_LEN; end
          else           w_len_ld = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_tmo)         begin w_err = 1'b1; w_err_code = ERR_TMO; end
        else if (rx_vld_i) w_wr_en = 1'b1;
      end
      ST_CSUM: begin
        if (w_tmo) begin
          w_err = 1'b1; w_err_code = ERR_TMO;
        end else if (rx_vld_i) begin
          if (rx_data_i == r_csum) begin w_ok = 1'b1; w_rd_idx_nxt = '0; end
          else                     begin w_err = 1'b1; w_err_code = ERR_CSUM; end
        end
      end
      ST_OUT: begin
        if (rx_vld_i) begin w_err = 1'b1; w_err_code = ERR_OVR; end
        if (w_xfer)   w_rd_idx_nxt = r_rd_idx + AW'(1);
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_len      <= '0;
      r_csum     <= '0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_idle     <= '0;
      r_pl_vld   <= 1'b0;
      r_pl_last  <= 1'b0;
      r_frm_ok   <= 1'b0;
      r_frm_err  <= 1'b0;
      r_err_code <= '0;
      r_busy     <= 1'b0;
    end else begin
      if (w_len_ld) begin
        r_len    <= rx_data_i;
        r_csum   <= rx_data_i;
        r_wr_idx <= '0;
      end else if (w_wr_en) begin
        r_csum   <= r_csum + rx_data_i;
        r_wr_idx <= r_wr_idx + AW'(1);
      end
      r_rd_idx <= w_rd_idx_nxt;
      if (rx_vld_i || (r_state == ST_HUNT0) || (r_state == ST_OUT)) r_idle <= '0;
      else if (r_idle != TIMEOUT_CYC)                               r_idle <= r_idle + 32'd1;
      r_pl_vld  <= (w_state_nxt == ST_OUT);
      r_pl_last <= (w_state_nxt == ST_OUT) && (8'(w_rd_idx_nxt) == (r_len - 8'd1));
      r_frm_ok  <= w_ok;
      r_frm_err <= w_err;
      if (w_err) r_err_code <= w_err_code;
      r_busy    <= (w_state_nxt != ST_HUNT0);
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_idx),
    .i_wdata (rx_data_i),
    .i_raddr (r_rd_idx),
    .o_rdata (w_rd_data)
  );

  assign pl_vld_o   = r_pl_vld;
  assign pl_data_o  = r_pl_vld ? w_rd_data : 8'd0;
  assign pl_last_o  = r_pl_last;
  assign frm_ok_o   = r_frm_ok;
  assign frm_err_o  = r_frm_err;
  assign err_code_o = r_err_code;
  assign busy_o     = r_busy;

endmodule
